// File: rtl/sideways_memory_pkg.sv
// Shared constants, types and ROM images for the BBC micro memory block.
package sideways_memory_pkg;

  localparam int KIB16 = 16;
  localparam int KIB32 = 32;
  localparam int SLOT_AW = 14;

  localparam logic [7:0] SHEILA_PAGE = 8'hFE;
  localparam logic [1:0] SW_TOP = 2'b10;

  localparam logic [15:0] DEF_RAM_MASK = 16'h00F0;
  localparam logic [15:0] DEF_POP_MASK = 16'h0003;

  typedef enum logic [1:0] {
    RG_MAIN,
    RG_SW,
    RG_OS,
    RG_SHEILA
  } region_t;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_PEND,
    LD_WR
  } ld_state_t;

  function automatic logic [7:0] fold(
    input logic [SLOT_AW-1:0] a
  );
    return a[7:0] ^ {2'b00, a[13:8]};
  endfunction

  // Synthetic images; a board build substitutes real ROM dumps.
  function automatic logic [7:0] rom_image(
    input logic [3:0] bank,
    input logic [SLOT_AW-1:0] a
  );
    return {bank, 4'h0} ^ fold(a);
  endfunction

  function automatic logic [7:0] os_image(
    input logic [SLOT_AW-1:0] a
  );
    return 8'hA5 ^ fold(a);
  endfunction

endpackage

// File: rtl/sideways_loader.sv
// Run-time bank loader: one captured beat, committed in a free CPU slot.
module sideways_loader
  import sideways_memory_pkg::*;
#(
  parameter int SLOTS = 16,
  parameter logic [15:0] RAM_MASK = DEF_RAM_MASK
) (
  input  logic clk,
  input  logic RESET,
  input  logic LD_VALID,
  output logic LD_READY,
  input  logic [3:0] LD_BANK,
  input  logic [SLOT_AW-1:0] LD_ADDR,
  input  logic [7:0] LD_DATA,
  output logic LD_ERR,
  input  logic cpu_free,
  output logic ld_we,
  output logic [3:0] ld_bank,
  output logic [SLOT_AW-1:0] ld_addr,
  output logic [7:0] ld_data
);

  ld_state_t state;
  logic bad_bank;

  assign bad_bank = (int'(LD_BANK) >= SLOTS)
                  || !RAM_MASK[LD_BANK];

  assign ld_we = (state == LD_PEND) && cpu_free;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state    <= LD_IDLE;
      LD_READY <= 1'b0;
      LD_ERR   <= 1'b0;
      ld_bank  <= '0;
      ld_addr  <= '0;
      ld_data  <= '0;
    end else begin
      unique case (state)
        LD_IDLE: begin
          LD_READY <= 1'b1;
          if (LD_VALID && LD_READY) begin
            if (bad_bank) begin
              LD_ERR <= 1'b1;
            end else begin
              ld_bank  <= LD_BANK;
              ld_addr  <= LD_ADDR;
              ld_data  <= LD_DATA;
              LD_READY <= 1'b0;
              state    <= LD_PEND;
            end
          end
        end
        LD_PEND: begin
          if (cpu_free) state <= LD_WR;
        end
        LD_WR: begin
          LD_READY <= 1'b1;
          state    <= LD_IDLE;
        end
        default: state <= LD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sideways_memory.sv
// Main RAM, MOS ROM, sideways slots, ROMSEL latch and loader port.
module sideways_memory
  import sideways_memory_pkg::*;
#(
  parameter int MAIN_KB = KIB32,
  parameter int SLOTS = 16,
  parameter logic [15:0] RAM_MASK = DEF_RAM_MASK,
  parameter logic [15:0] POP_MASK = DEF_POP_MASK,
  parameter int RESET_BANK = 0,
  localparam int BW = $clog2(SLOTS)
) (
  input  logic clk,
  input  logic RESET,
  input  logic RAM_en,
  input  logic PROC_en,
  input  logic V_TURN,
  input  logic [15:0] A,
  input  logic [7:0] DIN,
  input  logic RnW,
  input  logic nROMSEL,
  input  logic [14:0] VADDR,
  output logic [7:0] DOUT,
  output logic [7:0] VDATA,
  output logic [BW-1:0] ROM_BANK,
  input  logic LD_VALID,
  output logic LD_READY,
  input  logic [3:0] LD_BANK,
  input  logic [SLOT_AW-1:0] LD_ADDR,
  input  logic [7:0] LD_DATA,
  output logic LD_ERR
);

  localparam int MAIN_AW = (MAIN_KB == KIB16) ? 14 : 15;
  localparam int MAIN_BYTES = MAIN_KB * 1024;

  region_t rgn;
  logic cpu_slot;
  logic vid_slot;
  logic cpu_sw_we;
  logic cpu_free;
  logic [MAIN_AW-1:0] cpu_a;
  logic [MAIN_AW-1:0] vid_a;
  logic [7:0] cpu_rd;
  logic [7:0] main_ram [MAIN_BYTES];
  logic [7:0] sw_q [SLOTS];

  logic ld_we;
  logic [3:0] ld_bank;
  logic [SLOT_AW-1:0] ld_addr;
  logic [7:0] ld_data;

  // Truncation gives the 16 KiB alias of A[14] / VADDR[14].
  assign cpu_a = MAIN_AW'(A[14:0]);
  assign vid_a = MAIN_AW'(VADDR);

  assign cpu_slot = RAM_en && !V_TURN;
  assign vid_slot = RAM_en && V_TURN;

  always_comb begin
    rgn = RG_OS;
    unique case (1'b1)
      (A[15:8] == SHEILA_PAGE): rgn = RG_SHEILA;
      !A[15]:                   rgn = RG_MAIN;
      (A[15:14] == SW_TOP):     rgn = RG_SW;
      default:                  rgn = RG_OS;
    endcase
  end

  assign cpu_sw_we = cpu_slot && !RnW
                  && (rgn == RG_SW)
                  && RAM_MASK[ROM_BANK];

  // Only a CPU write into the loader's own slot holds it off.
  assign cpu_free = cpu_slot
                 && !((rgn == RG_SW) && !RnW
                      && (ROM_BANK == ld_bank[BW-1:0]));

  sideways_loader #(
    .SLOTS    (SLOTS),
    .RAM_MASK (RAM_MASK)
  ) u_loader (
    .clk      (clk),
    .RESET    (RESET),
    .LD_VALID (LD_VALID),
    .LD_READY (LD_READY),
    .LD_BANK  (LD_BANK),
    .LD_ADDR  (LD_ADDR),
    .LD_DATA  (LD_DATA),
    .LD_ERR   (LD_ERR),
    .cpu_free (cpu_free),
    .ld_we    (ld_we),
    .ld_bank  (ld_bank),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (cpu_slot && !RnW && (rgn == RG_MAIN))
      main_ram[cpu_a] <= DIN;
  end

  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    localparam logic [BW-1:0] SB = BW'(s);
    localparam logic [3:0] LB = 4'(s);
    if (RAM_MASK[s]) begin : g_ram
      logic [7:0] mem [1 << SLOT_AW];
      always_ff @(posedge clk) begin
        if (cpu_sw_we && (ROM_BANK == SB))
          mem[A[13:0]] <= DIN;
        else if (ld_we && (ld_bank == LB))
          mem[ld_addr] <= ld_data;
      end
      assign sw_q[s] = mem[A[13:0]];
    end else if (POP_MASK[s]) begin : g_rom
      assign sw_q[s] = rom_image(LB, A[13:0]);
    end else begin : g_empty
      assign sw_q[s] = 8'hFF;
    end
  end

  always_comb begin
    cpu_rd = 8'hFF;
    unique case (rgn)
      RG_MAIN: cpu_rd = main_ram[cpu_a];
      RG_SW:   cpu_rd = sw_q[ROM_BANK];
      RG_OS:   cpu_rd = os_image(A[13:0]);
      default: cpu_rd = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      DOUT     <= '0;
      VDATA    <= '0;
      ROM_BANK <= BW'(RESET_BANK);
    end else begin
      if (PROC_en && !nROMSEL)
        ROM_BANK <= DIN[BW-1:0];
      if (vid_slot)
        VDATA <= main_ram[vid_a];
      if (cpu_slot && RnW)
        DOUT <= cpu_rd;
    end
  end

endmodule

// File: tb/tb_sideways_memory.sv
// Directed bench for sideways_memory (16 KiB main RAM build).
module tb_sideways_memory;

  logic clk = 1'b0;
  logic RESET = 1'b1;
  logic RAM_en = 1'b0;
  logic PROC_en = 1'b0;
  logic V_TURN = 1'b0;
  logic [15:0] A = '0;
  logic [7:0] DIN = '0;
  logic RnW = 1'b1;
  logic nROMSEL = 1'b1;
  logic [14:0] VADDR = '0;
  logic [7:0] DOUT;
  logic [7:0] VDATA;
  logic [3:0] ROM_BANK;
  logic LD_VALID = 1'b0;
  logic LD_READY;
  logic [3:0] LD_BANK = '0;
  logic [13:0] LD_ADDR = '0;
  logic [7:0] LD_DATA = '0;
  logic LD_ERR;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sideways_memory #(.MAIN_KB(16)) dut (
    .clk      (clk),
    .RESET    (RESET),
    .RAM_en   (RAM_en),
    .PROC_en  (PROC_en),
    .V_TURN   (V_TURN),
    .A        (A),
    .DIN      (DIN),
    .RnW      (RnW),
    .nROMSEL  (nROMSEL),
    .VADDR    (VADDR),
    .DOUT     (DOUT),
    .VDATA    (VDATA),
    .ROM_BANK (ROM_BANK),
    .LD_VALID (LD_VALID),
    .LD_READY (LD_READY),
    .LD_BANK  (LD_BANK),
    .LD_ADDR  (LD_ADDR),
    .LD_DATA  (LD_DATA),
    .LD_ERR   (LD_ERR)
  );

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic slot(input logic [15:0] a,
                      input logic [7:0] d,
                      input logic rnw,
                      input logic nrs,
                      input logic vt);
    @(negedge clk);
    A = a; DIN = d; RnW = rnw; nROMSEL = nrs;
    V_TURN = vt; RAM_en = 1'b1; PROC_en = !vt;
    @(negedge clk);
    RAM_en = 1'b0; PROC_en = 1'b0;
    nROMSEL = 1'b1; RnW = 1'b1; V_TURN = 1'b0;
  endtask

  task automatic romsel(input logic [7:0] d);
    slot(16'hFE30, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic beat(input logic [3:0] b,
                      input logic [13:0] a,
                      input logic [7:0] d);
    @(negedge clk);
    LD_VALID = 1'b1; LD_BANK = b;
    LD_ADDR = a; LD_DATA = d;
    @(negedge clk);
    LD_VALID = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_dout", DOUT, 8'h00);
    chk("rst_vdata", VDATA, 8'h00);
    chk("rst_bank", {4'h0, ROM_BANK}, 8'h00);
    chk("rst_err", {7'h0, LD_ERR}, 8'h00);
    chk("rst_ready", {7'h0, LD_READY}, 8'h00);
    RESET = 1'b0;
    @(negedge clk);
    chk("rel_ready", {7'h0, LD_READY}, 8'h01);

    romsel(8'h01);
    chk("bank1", {4'h0, ROM_BANK}, 8'h01);
    slot(16'h8000, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("rd_s1_0", DOUT, 8'h10);
    romsel(8'h11);
    chk("bank_wrap", {4'h0, ROM_BANK}, 8'h01);

    slot(16'h8123, 8'hC3, 1'b0, 1'b1, 1'b0);
    chk("wr_keep_dout", DOUT, 8'h10);
    slot(16'h8123, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("rom_protect", DOUT, 8'h32);

    // read with old bank while ROMSEL switches to 4
    slot(16'h8000, 8'h04, 1'b1, 1'b0, 1'b0);
    chk("old_bank_rd", DOUT, 8'h10);
    chk("bank4", {4'h0, ROM_BANK}, 8'h04);
    slot(16'h8123, 8'hC3, 1'b0, 1'b1, 1'b0);
    slot(16'h8123, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("swram_rw", DOUT, 8'hC3);

    romsel(8'h02);
    slot(16'h8000, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("unpop", DOUT, 8'hFF);

    slot(16'h0010, 8'h5A, 1'b0, 1'b1, 1'b0);
    VADDR = 15'h4010;
    slot(16'h0000, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("vid_alias", VDATA, 8'h5A);
    chk("vid_no_cpu", DOUT, 8'hFF);
    slot(16'h4010, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("main_alias", DOUT, 8'h5A);

    slot(16'hC123, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("os_rd", DOUT, 8'h87);
    slot(16'hC123, 8'h99, 1'b0, 1'b1, 1'b0);
    slot(16'hC123, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("os_protect", DOUT, 8'h87);
    slot(16'hFE00, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("sheila_rd", DOUT, 8'hFF);

    beat(4'd5, 14'h0000, 8'hA5);
    chk("ld_busy0", {7'h0, LD_READY}, 8'h00);
    @(negedge clk);
    chk("ld_busy1", {7'h0, LD_READY}, 8'h00);
    slot(16'h0000, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("ld_busy2", {7'h0, LD_READY}, 8'h00);
    @(negedge clk);
    chk("ld_back", {7'h0, LD_READY}, 8'h01);
    romsel(8'h05);
    slot(16'h8000, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("ld_data", DOUT, 8'hA5);

    beat(4'd1, 14'h0000, 8'h00);
    chk("ld_err", {7'h0, LD_ERR}, 8'h01);
    chk("err_ready", {7'h0, LD_READY}, 8'h01);
    romsel(8'h01);
    slot(16'h8000, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("err_nowr", DOUT, 8'h10);

    romsel(8'h05);
    beat(4'd5, 14'h0000, 8'h22);
    slot(16'h8000, 8'h11, 1'b0, 1'b1, 1'b0);
    chk("cf_held", {7'h0, LD_READY}, 8'h00);
    slot(16'h8000, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("cf_cpu", DOUT, 8'h11);
    @(negedge clk);
    chk("cf_ready", {7'h0, LD_READY}, 8'h01);
    slot(16'h8000, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("cf_ld", DOUT, 8'h22);

    slot(16'h8010, 8'h3C, 1'b0, 1'b1, 1'b0);
    slot(16'h8010, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("pre_rst", DOUT, 8'h3C);
    beat(4'd5, 14'h0010, 8'h77);
    RESET = 1'b1;
    @(negedge clk);
    chk("rst2_ready", {7'h0, LD_READY}, 8'h00);
    @(negedge clk);
    RESET = 1'b0;
    @(negedge clk);
    chk("rst2_rdy", {7'h0, LD_READY}, 8'h01);
    chk("rst2_err", {7'h0, LD_ERR}, 8'h00);
    chk("rst2_dout", DOUT, 8'h00);
    chk("rst2_bank", {4'h0, ROM_BANK}, 8'h00);
    romsel(8'h05);
    slot(16'h8010, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("rst2_nowr", DOUT, 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sideways_memory.md
Name: sideways_memory

Overview:
- Parametrised memory subsystem for the BBC micro core. It replaces the fixed main-RAM, OS ROM and two-bank sideways logic with one block.
- Contains:
  - main RAM, sized 16 or 32 KiB;
  - MOS ROM;
  - N sideways slots, each configurable as ROM or write-enabled sideways RAM;
  - the ROMSEL latch;
  - CPU/video slot arbitration;
  - a valid/ready loader port for streaming bank images into sideways RAM at run time, e.g. from an SPI card.

Parameters:
- MAIN_KB, 32, main RAM size: 16 or 32 only. When 16, A[14] is ignored, so addresses alias.
- SLOTS, 16, number of sideways slots, power of two, 2..16. BW = log2(SLOTS).
- RAM_MASK, 16'h00F0, bit i set means slot i is sideways RAM (CPU-writable). Cleared bits are ROM.
- POP_MASK, 16'h0003, bit i set means slot i is populated. Unpopulated slots read 8'hFF.
- RESET_BANK, 0, ROMSEL value after reset.

Ports:
- clk  in  1  pixel clock
- RESET  in  1  asynchronous, active-high reset
- RAM_en  in  1  memory slot strobe
- PROC_en  in  1  processor cycle strobe
- V_TURN  in  1  current RAM_en slot belongs to video
- A  in  16  CPU address
- DIN  in  8  CPU write data
- RnW  in  1  CPU read(1)/write(0)
- nROMSEL  in  1  active-low ROMSEL write select, already qualified with ~RnW
- VADDR  in  15  video address, already corrected
- DOUT  out  8  CPU read data
- VDATA  out  8  video read data
- ROM_BANK  out  BW  current ROMSEL latch
- LD_VALID  in  1  loader beat valid
- LD_READY  out  1  loader can accept a beat
- LD_BANK  in  4  target slot
- LD_ADDR  in  14  offset within slot
- LD_DATA  in  8  byte to write
- LD_ERR  out  1  sticky: a loader beat targeted a non-RAM slot

Behaviour:
- Reset values:
  - DOUT = 0, VDATA = 0, ROM_BANK = RESET_BANK, LD_ERR = 0;
  - LD_READY = 0 while RESET is high, then 1 on the first clk after release;
  - loader FSM in IDLE.
- Region decode:
  - SHEILA = A[15:8] == FE;
  - OS = A[15:14] == 11 & ~SHEILA;
  - SW = A[15:14] == 10;
  - MAIN = ~A[15].
- ROMSEL:
  - on PROC_en & ~nROMSEL, ROM_BANK <= DIN[BW-1:0]; upper bits are ignored.
- Video slot (RAM_en & V_TURN):
  - VDATA <= main[VADDR], with the alias rule applied;
  - the CPU path is untouched.
- CPU slot (RAM_en & ~V_TURN):
  - RnW = 1: DOUT <= main, OS, or sideways[ROM_BANK] byte, depending on region.
  - SW read of an unpopulated slot returns FF. SHEILA reads return FF (DOUT undriven by peripherals here).
  - RnW = 0 & MAIN: write to main RAM.
  - RnW = 0 & SW & RAM_MASK[ROM_BANK]: write to sideways RAM.
  - Writes to OS, to ROM slots or to SHEILA are discarded. DOUT does not change on any write.
  - DOUT holds its value until the next CPU read slot. Latency is 1 clk after RAM_en.
- ROMSEL timing:
  - the sideways read uses the ROM_BANK value registered at that RAM_en edge;
  - a ROMSEL write in the same clk takes effect from the next slot.
- Loader FSM states: IDLE, PEND, WR.
  - IDLE: LD_READY = 1. On LD_VALID, capture bank, addr and data, then go to PEND. LD_READY = 0 from the next clk.
  - A captured bank with RAM_MASK bit clear, or bank >= SLOTS: set LD_ERR, drop the beat, stay in IDLE.
  - PEND: wait for RAM_en & ~V_TURN & ~(SW & ~RnW & ROM_BANK == captured bank). The CPU has priority only for a conflicting write. CPU reads use the read port; the loader uses the write port, so the two do not conflict.
  - WR: write the byte, then return to IDLE.
  - Throughput: at most one beat per CPU slot.
- Simultaneous CPU sideways write and loader write to the same slot:
  - the CPU write wins;
  - the loader stays in PEND until the next qualifying slot.
- RESET asserted in PEND or WR:
  - the pending beat is discarded, not written;
  - LD_ERR is cleared.
- Memory initialisation:
  - images via `include; unpopulated slots need no array;
  - sideways RAM slots initialise to 0 in SIMULATION.

Decomposition:
- Shared header (TOP.vh style): KiB16/KiB32 constants, SHEILA and region address constants, and the default RAM_MASK/POP_MASK.
- One sub-module: sideways_loader (IDLE/PEND/WR FSM plus capture registers). The memory arrays and decode stay in the parent.

Test Plan:
- ROMSEL: RESET, then write DIN = 8'h01 with nROMSEL low. Read 8000 in the next CPU slot: DOUT = slot-1 byte 0 and ROM_BANK = 1. DIN = 8'h11 with SLOTS = 16 gives ROM_BANK = 1.
- Write-protect: ROM_BANK = 1 (ROM). Write C3 to 8123, then read 8123: DOUT = original ROM byte. With ROM_BANK = 4 (RAM), the same sequence reads C3.
- Unpopulated slot: ROM_BANK = 2 (POP bit clear), read 8000 -> DOUT = FF. With MAIN_KB = 16, write 5A to 0010, then read 4010 -> 5A.
- Loader: LD_VALID with bank 5, addr 0000, data A5. LD_READY drops for 2 or more clks, then returns to 1. Set ROM_BANK = 5 and read 8000 -> A5. A beat with bank 1 sets LD_ERR = 1 and leaves slot 1 unchanged.
- Conflict: the CPU writes 11 to 8000 with ROM_BANK = 5 in the same slot as a pending loader beat of 22 to 5:0000. The slot ends as 11, and the loader commits 22 in the next qualifying slot.
- Reset: assert RESET while the loader is in PEND with data 77. The target byte stays unchanged; after release LD_READY = 1, LD_ERR = 0, DOUT = 0 and ROM_BANK = RESET_BANK.
